vexec_unit: RTL and testbench
=============================

# vexec_unit

Multi-cycle vector execution unit sitting directly downstream of the vector register file. It consumes the two 5-lane operand vectors read from the file (ra1 lanes, ra2 lanes). It processes one lane per cycle through a single shared 32-bit datapath (add/sub/mul/logic/reductions). It returns the result vector plus a one-cycle write-enable pulse that drives the register file's write port (wd1..wd5, we3).

## Interface
- WIDTH, 32, lane width in bits
- LANES, 5, maximum lanes per vector
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request pulse; sampled only in IDLE
- vop  in  3  operation: 000 add, 001 sub (a−b), 010 mul (low WIDTH bits), 011 and, 100 orr, 101 dot (Σ a·b), 110 sum (Σ a), 111 reserved
- vector_size  in  3  active lane count; values >LANES clamp to LANES
- vec_a  in  WIDTH*LANES  operand A, lane 0 in bits [WIDTH-1:0]
- vec_b  in  WIDTH*LANES  operand B, same packing
- busy  out  1  high from the cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- we3  out  1  one-cycle register-file write pulse, coincident with done
- wd  out  WIDTH*LANES  result vector, same packing; held until next accepted start

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 captures vec_a, vec_b, vop, clamped size n into internal registers. It also clears the lane index, the accumulator and the result vector. Next state is RUN if n>0, else DONE.
- RUN: each cycle processes lane i = index.
  - Elementwise ops write result lane i.
  - dot adds a[i]·b[i] (low WIDTH bits) to the accumulator, modulo 2^WIDTH.
  - sum adds a[i] to the accumulator.
  - After processing, i increments. When i == n−1, next state is DONE.
- DONE: done=1 for one cycle, then return to IDLE.
  - we3=1 if n>0, otherwise we3=0.
  - For dot and sum, result lane 0 equals the accumulator and lanes 1..LANES−1 are zero.
- Lanes ≥ n in wd are zero for every op.
- Reserved vop 111 runs the normal schedule but produces all-zero wd; we3 still pulses if n>0.
- All arithmetic is unsigned, wraps modulo 2^WIDTH, and has no flags.
- start while busy is ignored: no queuing and no change to captured operands.
- Input operand changes after capture have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, we3 0, wd all zero, index 0, accumulator 0.
- Reset asserted mid-operation aborts immediately with no done/we3. Operation resumes from IDLE after deassertion.
- Accepted start at edge T: busy=1 from T+1. RUN occupies cycles T+1..T+n. done/we3 are high in cycle T+n+1. busy drops and the FSM is back in IDLE at T+n+2.
- Latency for n lanes: n+1 cycles from start edge to done; size 0 gives 1 cycle.
- start may be asserted in the same cycle that done is high: it is ignored, because the FSM is not in IDLE. The earliest back-to-back start is in the cycle after done.
- wd updates only on the DONE transition. Partial results are not visible on wd during RUN.

## Test plan
- Add, size 5: A=all 2, B=3,4,5,6,7. Required: wd=5,6,7,8,9. done/we3 high exactly 6 cycles after the start edge, each for one cycle.
- Sub, size 3: A=all 2, B=3,4,5,6,7. Required: wd=FFFFFFFF, FFFFFFFE, FFFFFFFD, 0, 0. done 4 cycles after start.
- Dot, size 5: same operands. Required: lane0=50 (0x32), lanes1–4=0. Sum of A, size 5: lane0=10.
- Size 0, and size 7 clamp: size 0 gives done after 1 cycle with we3=0 and wd all zero. Size 7 add behaves identically to size 5 (done after 6 cycles).
- Reset at RUN cycle 3 of a size-5 op: busy, done and we3 go to 0 asynchronously, and wd is zero. A new size-2 start afterwards completes normally in 3 cycles.
- start pulsed during busy with different vop/operands: the original result is unchanged and no extra done pulse occurs.

Source files
------------

// File: rtl/vexec_if.sv
// Handshake and operand/result bundle between a requester and vexec_unit.
interface vexec_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 5
);
  logic                   start;
  logic [2:0]             vop;
  logic [2:0]             vector_size;
  logic [WIDTH*LANES-1:0] vec_a;
  logic [WIDTH*LANES-1:0] vec_b;
  logic                   busy;
  logic                   done;
  logic                   we3;
  logic [WIDTH*LANES-1:0] wd;

  modport master (
    output start, vop, vector_size, vec_a, vec_b,
    input  busy, done, we3, wd
  );

  modport slave (
    input  start, vop, vector_size, vec_a, vec_b,
    output busy, done, we3, wd
  );
endinterface

// File: rtl/vexec_unit.sv
// Multi-cycle vector execution unit: one lane per cycle through a shared datapath,
// result vector and register-file write pulse delivered in the DONE cycle.
module vexec_unit #(
  parameter int WIDTH = 32,
  parameter int LANES = 5
) (
  input  logic    clk,
  input  logic    reset,
  vexec_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ORR = 3'b100;
  localparam logic [2:0] OP_DOT = 3'b101;
  localparam logic [2:0] OP_SUM = 3'b110;

  localparam logic [2:0] LANES_N = 3'(LANES);

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q   [LANES];
  logic [WIDTH-1:0] a_d   [LANES];
  logic [WIDTH-1:0] b_q   [LANES];
  logic [WIDTH-1:0] b_d   [LANES];
  logic [WIDTH-1:0] res_q [LANES];
  logic [WIDTH-1:0] res_d [LANES];
  logic [WIDTH-1:0] wd_q  [LANES];
  logic [WIDTH-1:0] wd_d  [LANES];

  logic [2:0]       n_in;
  logic [WIDTH-1:0] lane_a, lane_b, prod, elem;
  logic             is_elem, is_red;

  assign n_in    = (bus.vector_size > LANES_N) ? LANES_N : bus.vector_size;
  assign is_elem = (op_q <= OP_ORR);
  assign is_red  = (op_q == OP_DOT) || (op_q == OP_SUM);

  // Shared lane datapath: operands selected by the current lane index
  always_comb begin
    lane_a = a_q[idx_q];
    lane_b = b_q[idx_q];
    prod   = lane_a * lane_b;
    case (op_q)
      OP_ADD:  elem = lane_a + lane_b;
      OP_SUB:  elem = lane_a - lane_b;
      OP_MUL:  elem = prod;
      OP_AND:  elem = lane_a & lane_b;
      OP_ORR:  elem = lane_a | lane_b;
      default: elem = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    op_d    = op_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int l = 0; l < LANES; l++) begin
            a_d[l]   = bus.vec_a[l*WIDTH +: WIDTH];
            b_d[l]   = bus.vec_b[l*WIDTH +: WIDTH];
            res_d[l] = '0;
          end
          op_d  = bus.vop;
          n_d   = n_in;
          idx_d = '0;
          acc_d = '0;
          if (n_in == 3'd0) begin
            state_d = S_DONE;
            for (int l = 0; l < LANES; l++) wd_d[l] = '0;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (is_elem) res_d[idx_q] = elem;
        if (op_q == OP_DOT)      acc_d = acc_q + prod;
        else if (op_q == OP_SUM) acc_d = acc_q + lane_a;
        idx_d = idx_q + 3'd1;
        // Result is published to wd only on the last lane, never mid-run
        if (idx_q == n_q - 3'd1) begin
          state_d = S_DONE;
          for (int l = 0; l < LANES; l++) begin
            if (is_red) wd_d[l] = (l == 0) ? acc_d : '0;
            else        wd_d[l] = res_d[l];
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      for (int l = 0; l < LANES; l++) begin
        a_q[l]   <= '0;
        b_q[l]   <= '0;
        res_q[l] <= '0;
        wd_q[l]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.we3  = (state_q == S_DONE) && (n_q != 3'd0);

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign bus.wd[g*WIDTH +: WIDTH] = wd_q[g];
  end

endmodule

// File: tb/tb_vexec_unit.sv
// Directed bench for vexec_unit: table of single operations plus reset/overlap sequences.
module tb_vexec_unit;
  localparam int WIDTH = 32;
  localparam int LANES = 5;
  localparam int VW    = WIDTH * LANES;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vexec_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  vexec_unit #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic [2:0]     size;
    logic [VW-1:0]  a;
    logic [VW-1:0]  b;
    logic [VW-1:0]  exp_wd;
    int             exp_lat;
    logic           exp_we;
  } vec_t;

  vec_t tv [13];

  function automatic logic [VW-1:0] pk(input logic [31:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input string nm, input logic [2:0] op, input logic [2:0] sz,
                              input logic [VW-1:0] a, input logic [VW-1:0] b,
                              input logic [VW-1:0] e, input int lat, input logic we);
    vec_t v;
    v.name = nm; v.op = op; v.size = sz; v.a = a; v.b = b;
    v.exp_wd = e; v.exp_lat = lat; v.exp_we = we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_start(input logic [2:0] op, input logic [2:0] sz,
                             input logic [VW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.vop = op; bus.vector_size = sz; bus.vec_a = a; bus.vec_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; called in the first cycle after the accepting edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    drive_start(v.op, v.size, v.a, v.b);
    chk({v.name, " busy"}, VW'(bus.busy), VW'(1));
    wait_done(lat);
    chk({v.name, " latency"}, VW'(lat), VW'(v.exp_lat));
    chk({v.name, " we3"}, VW'(bus.we3), VW'(v.exp_we));
    chk({v.name, " wd"}, bus.wd, v.exp_wd);
    @(negedge clk);
    chk({v.name, " pulse end"}, VW'({bus.done, bus.we3, bus.busy}), VW'(0));
    chk({v.name, " wd held"}, bus.wd, v.exp_wd);
  endtask

  logic [VW-1:0] a2, b37, r_add;

  initial begin
    int lat;
    int extra;
    a2    = pk(2, 2, 2, 2, 2);
    b37   = pk(3, 4, 5, 6, 7);
    r_add = pk(5, 6, 7, 8, 9);

    tv[0]  = mk("add5",   3'b000, 3'd5, a2, b37, r_add, 6, 1'b1);
    tv[1]  = mk("sub3",   3'b001, 3'd3, a2, b37,
                pk(32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0), 4, 1'b1);
    tv[2]  = mk("dot5",   3'b101, 3'd5, a2, b37, pk(50, 0, 0, 0, 0), 6, 1'b1);
    tv[3]  = mk("sum5",   3'b110, 3'd5, a2, b37, pk(10, 0, 0, 0, 0), 6, 1'b1);
    tv[4]  = mk("size0",  3'b000, 3'd0, a2, b37, '0, 1, 1'b0);
    tv[5]  = mk("clamp7", 3'b000, 3'd7, a2, b37, r_add, 6, 1'b1);
    tv[6]  = mk("mul4",   3'b010, 3'd4, a2, b37, pk(6, 8, 10, 12, 0), 5, 1'b1);
    tv[7]  = mk("and2",   3'b011, 3'd2, pk(32'hF0F0F0F0, 32'h0000FFFF, 9, 9, 9),
                pk(32'hFF00FF00, 32'h12345678, 9, 9, 9),
                pk(32'hF000F000, 32'h00005678, 0, 0, 0), 3, 1'b1);
    tv[8]  = mk("orr5",   3'b100, 3'd5, pk(1, 2, 4, 8, 32'h10),
                pk(32'h100, 32'h200, 32'h400, 32'h800, 32'h1000),
                pk(32'h101, 32'h202, 32'h404, 32'h808, 32'h1010), 6, 1'b1);
    tv[9]  = mk("rsvd3",  3'b111, 3'd3, a2, b37, '0, 4, 1'b1);
    tv[10] = mk("mulwrap",3'b010, 3'd1, pk(32'hFFFFFFFF, 5, 5, 5, 5), pk(2, 5, 5, 5, 5),
                pk(32'hFFFFFFFE, 0, 0, 0, 0), 2, 1'b1);
    tv[11] = mk("dotwrap",3'b101, 3'd2, pk(32'hFFFFFFFF, 2, 1, 1, 1), pk(2, 3, 1, 1, 1),
                pk(4, 0, 0, 0, 0), 3, 1'b1);
    tv[12] = mk("sum1",   3'b110, 3'd1, pk(7, 1, 1, 1, 1), b37, pk(7, 0, 0, 0, 0), 2, 1'b1);

    bus.start = 1'b0; bus.vop = '0; bus.vector_size = '0; bus.vec_a = '0; bus.vec_b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", VW'({bus.busy, bus.done, bus.we3}), VW'(0));
    chk("reset wd", bus.wd, '0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tv[i]);

    // Asynchronous reset in the third RUN cycle of a size-5 add
    run_vec(tv[0]);
    drive_start(3'b000, 3'd5, a2, b37);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort outputs", VW'({bus.busy, bus.done, bus.we3}), VW'(0));
    chk("abort wd", bus.wd, '0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.we3) extra++;
    end
    chk("abort no done", VW'(extra), VW'(0));
    drive_start(3'b000, 3'd2, a2, b37);
    wait_done(lat);
    chk("post-reset latency", VW'(lat), VW'(3));
    chk("post-reset wd", bus.wd, pk(5, 6, 0, 0, 0));
    @(negedge clk);

    // start while busy (and in the done cycle) is ignored
    drive_start(3'b000, 3'd5, a2, b37);
    @(negedge clk);
    bus.start = 1'b1; bus.vop = 3'b001; bus.vector_size = 3'd1;
    bus.vec_a = pk(100, 100, 100, 100, 100); bus.vec_b = pk(1, 1, 1, 1, 1);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("overlap latency", VW'(lat), VW'(6));
    chk("overlap wd", bus.wd, r_add);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done-cycle start ignored", VW'(bus.busy), VW'(0));
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    chk("no extra done", VW'(extra), VW'(0));
    chk("overlap wd held", bus.wd, r_add);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
